// File: rtl/ps2_keyboard_rx_if.sv
// Key-event bundle between the PS/2 receiver and its consumer: raw keyboard
// lines in, decoded scan-code nibbles, flags and strobes out.
interface ps2_keyboard_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] hex1;
  logic [3:0] hex0;
  logic       keyup;
  logic       ext;
  logic       code_valid;
  logic       frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output hex1, hex0, keyup, ext, code_valid, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  hex1, hex0, keyup, ext, code_valid, frame_err
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronise and de-glitch the keyboard lines, deframe
// 11-bit frames, fold F0/E0 prefixes into flags. `PS2_TIMEOUT_EN adds a frame watchdog.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input logic               clk,
  input logic               reset,
  ps2_keyboard_rx_if.master bus
);

  localparam int FCW = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic           clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
  logic           data_meta_q, data_meta_d, data_sync_q, data_sync_d;
  logic [FCW-1:0] clk_cnt_q, clk_cnt_d, data_cnt_q, data_cnt_d;
  logic           clk_filt_q, clk_filt_d, data_filt_q, data_filt_d;
  logic           clk_prev_q, clk_prev_d;
  logic           fall_stb;

  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic           break_pending_q, break_pending_d;
  logic           ext_pending_q, ext_pending_d;
  logic [7:0]     hex_q, hex_d;
  logic           keyup_q, keyup_d;
  logic           ext_q, ext_d;
  logic           code_valid_q, code_valid_d;
  logic           frame_err_q, frame_err_d;

`ifdef PS2_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
`endif

  // A filtered line only follows its synchronised input after FILTER_LEN equal samples.
  always_comb begin
    clk_meta_d  = bus.ps2_clk;
    clk_sync_d  = clk_meta_q;
    data_meta_d = bus.ps2_data;
    data_sync_d = data_meta_q;
    clk_cnt_d   = '0;
    clk_filt_d  = clk_filt_q;
    data_cnt_d  = '0;
    data_filt_d = data_filt_q;
    clk_prev_d  = clk_filt_q;
    if (clk_sync_q != clk_filt_q) begin
      if (clk_cnt_q == FCW'(FILTER_LEN - 1)) clk_filt_d = clk_sync_q;
      else                                   clk_cnt_d  = clk_cnt_q + 1'b1;
    end
    if (data_sync_q != data_filt_q) begin
      if (data_cnt_q == FCW'(FILTER_LEN - 1)) data_filt_d = data_sync_q;
      else                                    data_cnt_d  = data_cnt_q + 1'b1;
    end
  end

  assign fall_stb = clk_prev_q & ~clk_filt_q;

  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    parity_d        = parity_q;
    break_pending_d = break_pending_q;
    ext_pending_d   = ext_pending_q;
    hex_d           = hex_q;
    keyup_d         = keyup_q;
    ext_d           = ext_q;
    code_valid_d    = 1'b0;
    frame_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_stb && !data_filt_q) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall_stb) begin
          shift_d   = {data_filt_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall_stb) begin
          parity_d = data_filt_q;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall_stb) begin
          state_d = IDLE;
          // Odd parity over data plus parity bit, and a high stop bit.
          if (data_filt_q && (^{shift_q, parity_q})) begin
            if (shift_q == 8'hF0) begin
              break_pending_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
              ext_pending_d = 1'b1;
            end else begin
              hex_d           = shift_q;
              keyup_d         = break_pending_q;
              ext_d           = ext_pending_q;
              code_valid_d    = 1'b1;
              break_pending_d = 1'b0;
              ext_pending_d   = 1'b0;
            end
          end else begin
            frame_err_d     = 1'b1;
            break_pending_d = 1'b0;
            ext_pending_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PS2_TIMEOUT_EN
    to_cnt_d = (state_q == IDLE || fall_stb) ? '0 : to_cnt_q + 1'b1;
    if (state_q != IDLE && !fall_stb && to_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
      state_d         = IDLE;
      frame_err_d     = 1'b1;
      break_pending_d = 1'b0;
      ext_pending_d   = 1'b0;
      to_cnt_d        = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_meta_q      <= 1'b1;
      clk_sync_q      <= 1'b1;
      data_meta_q     <= 1'b1;
      data_sync_q     <= 1'b1;
      clk_cnt_q       <= '0;
      data_cnt_q      <= '0;
      clk_filt_q      <= 1'b1;
      data_filt_q     <= 1'b1;
      clk_prev_q      <= 1'b1;
      state_q         <= IDLE;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      parity_q        <= 1'b0;
      break_pending_q <= 1'b0;
      ext_pending_q   <= 1'b0;
      hex_q           <= '0;
      keyup_q         <= 1'b1;
      ext_q           <= 1'b0;
      code_valid_q    <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      clk_meta_q      <= clk_meta_d;
      clk_sync_q      <= clk_sync_d;
      data_meta_q     <= data_meta_d;
      data_sync_q     <= data_sync_d;
      clk_cnt_q       <= clk_cnt_d;
      data_cnt_q      <= data_cnt_d;
      clk_filt_q      <= clk_filt_d;
      data_filt_q     <= data_filt_d;
      clk_prev_q      <= clk_prev_d;
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      parity_q        <= parity_d;
      break_pending_q <= break_pending_d;
      ext_pending_q   <= ext_pending_d;
      hex_q           <= hex_d;
      keyup_q         <= keyup_d;
      ext_q           <= ext_d;
      code_valid_q    <= code_valid_d;
      frame_err_q     <= frame_err_d;
    end
  end

`ifdef PS2_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`endif

  assign bus.hex1       = hex_q[7:4];
  assign bus.hex0       = hex_q[3:0];
  assign bus.keyup      = keyup_q;
  assign bus.ext        = ext_q;
  assign bus.code_valid = code_valid_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: frame-level key-event model with a per-cycle
// compare process, plus literal checks of the decoded outputs.
module tb_ps2_keyboard_rx;

  localparam int FL   = 8;
  localparam int TO   = 2000;
  localparam int HALF = 40;

  typedef struct {
    bit         err;
    logic [7:0] code;
    bit         keyup;
    bit         ext;
    int         lo;
    int         hi;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  ev_t        exp_q[$];
  logic [7:0] m_code  = 8'h00;
  bit         m_keyup = 1'b1;
  bit         m_ext   = 1'b0;
  bit         m_brk   = 1'b0;
  bit         m_e0    = 1'b0;

  ps2_keyboard_rx_if bus();

  ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clock_bit(input bit b);
    bus.ps2_data = b;
    wait_cycles(HALF);
    bus.ps2_clk = 1'b0;
    wait_cycles(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  // Sends a frame from data bit 'from' onward (0 also sends the start bit);
  // the expected key event is queued right as the stop bit is clocked.
  task automatic applyStimulus(input logic [7:0] code, input bit par_ok, input bit stop_bit,
                               input int from);
    logic par;
    bit   good;
    ev_t  ev;
    par = par_ok ? ~^code : ^code;
    if (from == 0) clock_bit(1'b0);
    for (int i = from; i < 8; i++) clock_bit(code[i]);
    clock_bit(par);
    bus.ps2_data = stop_bit;
    wait_cycles(HALF);
    good = stop_bit && ($countones({code, par}) % 2 == 1);
    ev.err = !good; ev.code = code; ev.keyup = m_brk; ev.ext = m_e0;
    ev.lo = cyc + FL + 2; ev.hi = cyc + FL + 4;
    if (!good) begin
      exp_q.push_back(ev); m_brk = 0; m_e0 = 0;
    end else if (code == 8'hF0) begin
      m_brk = 1;
    end else if (code == 8'hE0) begin
      m_e0 = 1;
    end else begin
      exp_q.push_back(ev); m_brk = 0; m_e0 = 0;
    end
    bus.ps2_clk = 1'b0;
    wait_cycles(HALF);
    bus.ps2_clk = 1'b1;
    wait_cycles(HALF);
    bus.ps2_data = 1'b1;
    wait_cycles(4 * HALF);
  endtask

  task automatic send(input logic [7:0] code);
    applyStimulus(code, 1'b1, 1'b1, 0);
  endtask

  task automatic check_lit(input logic [3:0] h1, input logic [3:0] h0, input bit ku,
                           input bit ex, input string tag);
    checkOutput({tag, "_hex1"}, bus.hex1, h1);
    checkOutput({tag, "_hex0"}, bus.hex0, h0);
    checkOutput({tag, "_keyup"}, bus.keyup, ku);
    checkOutput({tag, "_ext"}, bus.ext, ex);
  endtask

  // Per-cycle comparison against the key-event model.
  always @(negedge clk) begin
    ev_t ev;
    if (!reset) begin
      checkOutput("rst_code_valid", bus.code_valid, 0);
      checkOutput("rst_frame_err", bus.frame_err, 0);
      checkOutput("rst_hex", {bus.hex1, bus.hex0}, 0);
      checkOutput("rst_keyup", bus.keyup, 1);
      checkOutput("rst_ext", bus.ext, 0);
      m_code = 8'h00; m_keyup = 1'b1; m_ext = 1'b0;
    end else begin
      checkOutput("strobe_overlap", bus.code_valid & bus.frame_err, 0);
      if (bus.code_valid || bus.frame_err) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_strobe", {bus.code_valid, bus.frame_err}, 0);
        end else begin
          ev = exp_q.pop_front();
          checkOutput("strobe_kind_err", bus.frame_err, ev.err);
          checkOutput("strobe_not_early", cyc >= ev.lo, 1);
          checkOutput("strobe_not_late", cyc <= ev.hi, 1);
          if (!ev.err) begin
            m_code = ev.code; m_keyup = ev.keyup; m_ext = ev.ext;
          end
        end
      end else if (exp_q.size() != 0) begin
        checkOutput("strobe_missing", cyc <= exp_q[0].hi, 1);
        if (cyc > exp_q[0].hi) void'(exp_q.pop_front());
      end
      checkOutput("hold_hex1", bus.hex1, m_code[7:4]);
      checkOutput("hold_hex0", bus.hex0, m_code[3:0]);
      checkOutput("hold_keyup", bus.keyup, m_keyup);
      checkOutput("hold_ext", bus.ext, m_ext);
    end
  end

  initial begin
    logic [7:0] k75;
    k75 = 8'h75;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset        = 1'b0;
    wait_cycles(5);
    check_lit(4'h0, 4'h0, 1'b1, 1'b0, "reset");
    reset = 1'b1;
    wait_cycles(20);

    send(8'h75);
    check_lit(4'h7, 4'h5, 1'b0, 1'b0, "make75");

    send(8'hF0);
    check_lit(4'h7, 4'h5, 1'b0, 1'b0, "after_f0");
    send(8'h72);
    check_lit(4'h7, 4'h2, 1'b1, 1'b0, "break72");

    send(8'hE0);
    send(8'h75);
    check_lit(4'h7, 4'h5, 1'b0, 1'b1, "ext75");
    send(8'h75);
    check_lit(4'h7, 4'h5, 1'b0, 1'b0, "plain75");

    send(8'h72);
    check_lit(4'h7, 4'h2, 1'b0, 1'b0, "repeat72");
    send(8'h72);
    check_lit(4'h7, 4'h2, 1'b0, 1'b0, "repeat72b");

    applyStimulus(8'h72, 1'b0, 1'b1, 0);
    check_lit(4'h7, 4'h2, 1'b0, 1'b0, "bad_parity");
    send(8'hF0);
    applyStimulus(8'h1C, 1'b1, 1'b0, 0);
    send(8'h75);
    check_lit(4'h7, 4'h5, 1'b0, 1'b0, "after_bad_stop");

    // Stalled frame: start bit plus four data bits, then a long idle clock.
    send(8'hE0);
    clock_bit(1'b0);
    for (int i = 0; i < 4; i++) clock_bit(k75[i]);
`ifdef PS2_TIMEOUT_EN
    begin
      ev_t ev;
      ev.err = 1'b1; ev.code = 8'h00; ev.keyup = 1'b0; ev.ext = 1'b0;
      ev.lo = cyc + TO / 2; ev.hi = cyc + TO + 50;
      exp_q.push_back(ev);
      m_brk = 0; m_e0 = 0;
    end
    wait_cycles(2 * TO);
`else
    wait_cycles(2 * TO);
    applyStimulus(8'h75, 1'b1, 1'b1, 4);
    check_lit(4'h7, 4'h5, 1'b0, 1'b1, "stalled_completes");
`endif
    send(8'h75);
    check_lit(4'h7, 4'h5, 1'b0, 1'b0, "after_stall");

    bus.ps2_clk = 1'b0;
    wait_cycles(3);
    bus.ps2_clk = 1'b1;
    wait_cycles(50);
    send(8'h6B);
    check_lit(4'h6, 4'hB, 1'b0, 1'b0, "after_glitch");

    // Reset pulse in the high phase of the fifth data bit.
    send(8'hF0);
    clock_bit(1'b0);
    for (int i = 0; i < 5; i++) clock_bit(k75[i]);
    wait_cycles(20);
    reset = 1'b0;
    m_brk = 0; m_e0 = 0;
    wait_cycles(4);
    check_lit(4'h0, 4'h0, 1'b1, 1'b0, "mid_reset");
    reset = 1'b1;
    bus.ps2_data = 1'b1;
    wait_cycles(100);
    check_lit(4'h0, 4'h0, 1'b1, 1'b0, "post_reset");
    send(8'h75);
    check_lit(4'h7, 4'h5, 1'b0, 1'b0, "after_reset");

    wait_cycles(50);
    checkOutput("events_outstanding", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard receiver that deserializes the keyboard's ps2_clk/ps2_data stream into scan codes for the volume-control logic. Each received key event is presented as two hex nibbles plus a key-release flag, with a one-cycle valid strobe. Break (F0) and extended (E0) prefixes are folded into flags, so downstream consumers only ever see complete key events.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive identical samples required before the filtered ps2_clk/ps2_data change level.
- TIMEOUT_CYCLES, 200000: maximum clk cycles between filtered ps2_clk falling edges inside a frame (2 ms at 100 MHz).

Ports:
- clk  input  1  system clock, 100 MHz; single clock domain.
- reset  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw keyboard clock, asynchronous.
- ps2_data  input  1  raw keyboard data, asynchronous.
- hex1  output  4  upper nibble of the last scan code.
- hex0  output  4  lower nibble of the last scan code.
- keyup  output  1  1 = last event was a release (F0-prefixed); 0 = press or typematic repeat.
- ext  output  1  1 = last event was E0-prefixed.
- code_valid  output  1  one-cycle strobe; hex1, hex0, keyup and ext updated this cycle.
- frame_err  output  1  one-cycle strobe on a parity, stop-bit or timeout failure.

## Operation
- Input path: a 2-flop synchronizer on each line, then a per-line glitch filter. The filtered level changes only after FILTER_LEN consecutive equal synchronized samples.
- Edge strobe: asserted for one cycle when the filtered ps2_clk goes from 1 to 0. The filtered ps2_data is sampled in that same cycle.
- FSM states: IDLE, DATA, PARITY, STOP. Every transition happens on an edge strobe.
  - IDLE: a sampled 0 (start bit) moves to DATA and clears the bit counter. A sampled 1 stays in IDLE.
  - DATA: shifts in 8 bits, LSB first, into bits [7:0]. After the 8th bit, moves to PARITY.
  - PARITY: captures the parity bit, then moves to STOP.
  - STOP: always returns to IDLE. The frame is good only if the stop bit is 1 and data plus parity has an odd count of ones.
- Good frame, byte F0: sets break_pending. No outputs change.
- Good frame, byte E0: sets ext_pending. No outputs change.
- Good frame, any other byte:
  - {hex1,hex0} <= byte.
  - keyup <= break_pending.
  - ext <= ext_pending.
  - Both pending flags clear.
  - code_valid pulses.
- Bad frame: frame_err pulses, the byte is discarded, both pending flags clear, and the data outputs hold.
- Data outputs hold their value until the next good non-prefix byte.
- Reset values:
  - hex1 = 0, hex0 = 0.
  - keyup = 1, so consumers see no key pressed.
  - ext = 0, code_valid = 0, frame_err = 0.
  - FSM in IDLE, both pending flags 0.
  - Filters initialised to 1, matching an idle bus.
- Reset asserted mid-frame: the partial frame is discarded and no strobe is issued. After release, the first start bit begins a fresh frame.

## Timing
- Raw-pin transition to filtered transition: 2 + FILTER_LEN clk cycles.
- code_valid and frame_err rise in the cycle after the edge strobe that samples the stop bit, and last exactly one cycle.
- The data outputs change in the same cycle code_valid is high.
- code_valid and frame_err are never high together.
- Typematic repeat of the same make code produces a new code_valid each time, with identical hex values and keyup = 0.
- The host-to-keyboard direction is not supported. The inputs are never driven.

## Configuration
- PS2_TIMEOUT_EN defined:
  - A cycle counter runs in DATA, PARITY and STOP and resets on each edge strobe.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE, frame_err pulses and both pending flags clear.
- PS2_TIMEOUT_EN undefined:
  - No counter is built and the FSM waits indefinitely for the next edge.
  - frame_err then signals only parity and stop-bit failures.

## Test plan
- Frame 0x75, valid parity, 12.5 kHz ps2_clk -> one code_valid; hex1=7, hex0=5, keyup=0, ext=0.
- Frames F0 then 0x72 -> exactly one code_valid, after 0x72; hex1=7, hex0=2, keyup=1.
- Frames E0, 0x75 -> one code_valid; ext=1, keyup=0. A following plain 0x75 -> ext=0.
- Frame 0x72 with the parity bit inverted -> frame_err pulse, no code_valid, outputs unchanged. A following good 0x75 decodes correctly.
- With PS2_TIMEOUT_EN: start bit plus 4 data bits, then ps2_clk held high for more than 200000 cycles -> one frame_err pulse and FSM back in IDLE. A following 0x75 decodes. Without PS2_TIMEOUT_EN: no frame_err is issued.
- A 3-cycle low glitch on ps2_clk while idle -> no state change. reset pulsed low during the 5th data bit -> all outputs at reset values and no strobes. A following 0x75 decodes.
